// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage registered pipeline with valid/ready flow control,
// bubble collapsing and synchronous flush.
module dff_pipe #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         i_flush,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [WIDTH-1:0]             i_in_data,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [WIDTH-1:0]             o_out_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            w_v;
    logic [DEPTH-1:0][WIDTH-1:0] w_d;
    logic [DEPTH:0]              w_rdy;
    logic                        w_acc;
    logic                        w_xin;
    logic                        w_xout;
    logic [CW-1:0]               r_occ;

    // Stage i may load if any stage from i to the tail is empty or the sink
    // accepts; this is the unrolled form of r[i] = !v[i] | r[i+1].
    always_comb begin
        w_rdy = '0;
        w_acc = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            w_acc = i_out_ready;
            for (int j = i; j < DEPTH; j++)
                w_acc = w_acc | !w_v[j];
            w_rdy[i] = w_acc;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             r_v;
        logic [WIDTH-1:0] r_d;
        logic             w_src_v;
        logic [WIDTH-1:0] w_src_d;

        if (i == 0) begin : g_head
            assign w_src_v = i_in_valid;
            assign w_src_d = i_in_data;
        end else begin : g_body
            assign w_src_v = w_v[i-1];
            assign w_src_d = w_d[i-1];
        end

        // Data only captured alongside a valid word so idle stages don't toggle.
        always_ff @(posedge clk) begin
            if (!resetn || i_flush) begin
                r_v <= 1'b0;
                r_d <= RESET_VAL;
            end else if (w_rdy[i]) begin
                r_v <= w_src_v;
                if (w_src_v)
                    r_d <= w_src_d;
            end
        end

        assign w_v[i] = r_v;
        assign w_d[i] = r_d;
    end

    assign o_in_ready  = w_rdy[0] & !i_flush;
    assign o_out_valid = w_v[DEPTH-1] & !i_flush;
    assign o_out_data  = w_d[DEPTH-1];

    assign w_xin  = i_in_valid & o_in_ready;
    assign w_xout = o_out_valid & i_out_ready;

    always_ff @(posedge clk) begin
        if (!resetn || i_flush)
            r_occ <= '0;
        else
            r_occ <= r_occ + CW'(w_xin) - CW'(w_xout);
    end

    assign o_occupancy = r_occ;

    a_occ_matches_valid: assert property (@(posedge clk)
        resetn |-> (r_occ == CW'($countones(w_v))));

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: DEPTH=4 and DEPTH=1 instances on shared stimulus, checked
// every cycle against a word-queue model plus directed literal expectations.
module tb_dff_pipe;
    localparam logic [7:0] RV = 8'hC3;

    logic       clk = 1'b0;
    logic       resetn, flush, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready4, out_valid4, in_ready1, out_valid1;
    logic [7:0] out_data4, out_data1;
    logic [2:0] occ4;
    logic [0:0] occ1;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV)) u_dut4 (
        .clk(clk), .resetn(resetn), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(in_ready4), .i_in_data(in_data),
        .o_out_valid(out_valid4), .i_out_ready(out_ready), .o_out_data(out_data4),
        .o_occupancy(occ4));

    dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(RV)) u_dut1 (
        .clk(clk), .resetn(resetn), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(in_ready1), .i_in_data(in_data),
        .o_out_valid(out_valid1), .i_out_ready(out_ready), .o_out_data(out_data1),
        .o_occupancy(occ1));

    // Model: per instance, an ordered list of words (oldest first), each with
    // the stage position it sits in; last[] is what the final stage holds.
    int         dep[2] = '{4, 1};
    int         n[2];
    int         pos[2][8];
    logic [7:0] dat[2][8];
    logic [7:0] last[2];

    function automatic logic [7:0] moves_of(int m);
        logic [7:0] mv;
        mv = '0;
        for (int k = 0; k < n[m]; k++) begin
            if (k == 0) mv[0] = (pos[m][0] < dep[m] - 1) || out_ready;
            else        mv[k] = (pos[m][k] + 1 < pos[m][k-1]) || mv[k-1];
        end
        return mv;
    endfunction

    function automatic logic can_accept(int m);
        logic [7:0] mv;
        if (flush) return 1'b0;
        if (n[m] == 0) return 1'b1;
        mv = moves_of(m);
        return (pos[m][n[m]-1] > 0) || mv[n[m]-1];
    endfunction

    function automatic logic pred_ov(int m);
        return !flush && n[m] > 0 && pos[m][0] == dep[m] - 1;
    endfunction

    task automatic model_step(int m);
        logic [7:0] mv;
        logic       acc;
        if (!resetn || flush) begin
            n[m]    = 0;
            last[m] = RV;
            return;
        end
        mv  = moves_of(m);
        acc = in_valid && can_accept(m);
        for (int k = 0; k < n[m]; k++)
            if (mv[k]) pos[m][k] = pos[m][k] + 1;
        if (n[m] > 0 && pos[m][0] == dep[m]) begin
            for (int k = 0; k < n[m] - 1; k++) begin
                pos[m][k] = pos[m][k+1];
                dat[m][k] = dat[m][k+1];
            end
            n[m] = n[m] - 1;
        end
        if (acc) begin
            pos[m][n[m]] = 0;
            dat[m][n[m]] = in_data;
            n[m] = n[m] + 1;
        end
        if (n[m] > 0 && pos[m][0] == dep[m] - 1)
            last[m] = dat[m][0];
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        n[0] = 0; n[1] = 0; last[0] = RV; last[1] = RV;
        forever begin
            @(posedge clk);
            model_step(0);
            model_step(1);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("m_in_ready4",  32'(in_ready4),  32'(can_accept(0)));
                check("m_out_valid4", 32'(out_valid4), 32'(pred_ov(0)));
                check("m_out_data4",  32'(out_data4),  32'(last[0]));
                check("m_occ4",       32'(occ4),       32'(n[0]));
                check("m_in_ready1",  32'(in_ready1),  32'(can_accept(1)));
                check("m_out_valid1", 32'(out_valid1), 32'(pred_ov(1)));
                check("m_out_data1",  32'(out_data1),  32'(last[1]));
                check("m_occ1",       32'(occ1),       32'(n[1]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
        tick(); tick();
        resetn = 1'b0;
        #1;
        // reset: nothing captured, outputs at reset value
        check("rst_out_valid4", 32'(out_valid4), 0);
        check("rst_out_data4",  32'(out_data4),  32'h0C3);
        check("rst_occ4",       32'(occ4),       0);
        check("rst_out_data1",  32'(out_data1),  32'h0C3);
        resetn = 1'b1; in_valid = 1'b0;
        chk_en = 1'b1;

        // stream 0x01..0x10 back to back
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            tick();
            if (i >= 4) begin
                check("stream_data", 32'(out_data4), 32'(i - 3));
                check("stream_occ",  32'(occ4), 4);
            end
        end
        in_valid = 1'b0;
        repeat (5) tick();

        // stall/fill
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'hA1 + 8'(i);
            tick();
        end
        in_data = 8'hA5;
        #1;
        check("stall_in_ready", 32'(in_ready4), 0);
        check("stall_occ",      32'(occ4), 4);
        check("stall_head",     32'(out_data4), 32'h0A1);
        tick(); tick();
        check("stall_hold_occ", 32'(occ4), 4);
        check("stall_hold_hd",  32'(out_data4), 32'h0A1);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready4), 1);
        tick();
        check("drain_a2", 32'(out_data4), 32'h0A2);
        in_data = 8'hA6;
        tick();
        check("drain_a3", 32'(out_data4), 32'h0A3);
        check("drain_occ", 32'(occ4), 4);
        in_valid = 1'b0;
        tick(); check("drain_a4", 32'(out_data4), 32'h0A4);
        tick(); check("drain_a5", 32'(out_data4), 32'h0A5);
        tick(); check("drain_a6", 32'(out_data4), 32'h0A6);
        tick(); check("drain_empty", 32'(occ4), 0);

        // bubbles collapse behind a stalled head
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hB1; tick();
        in_valid = 1'b0;                  tick();
        in_valid = 1'b1; in_data = 8'hB2; tick();
        in_valid = 1'b0;                  tick();
        check("bub_occ",   32'(occ4), 2);
        check("bub_valid", 32'(out_valid4), 1);
        check("bub_head",  32'(out_data4), 32'h0B1);
        tick(); tick();
        check("bub_hold_occ", 32'(occ4), 2);
        out_ready = 1'b1;
        tick();
        check("bub_b2",     32'(out_data4), 32'h0B2);
        check("bub_occ1",   32'(occ4), 1);
        tick();
        check("bub_empty",  32'(occ4), 0);
        check("bub_novld",  32'(out_valid4), 0);

        // flush with input presented
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hC1; tick();
        in_data = 8'hC2; tick();
        in_data = 8'hC3; tick();
        in_valid = 1'b0; tick();
        check("pre_flush_occ", 32'(occ4), 3);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        #1;
        check("flush_in_ready",  32'(in_ready4), 0);
        check("flush_out_valid", 32'(out_valid4), 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("post_flush_occ",  32'(occ4), 0);
        check("post_flush_vld",  32'(out_valid4), 0);
        check("post_flush_data", 32'(out_data4), 32'h0C3);
        in_valid = 1'b1; in_data = 8'h66; tick();
        in_valid = 1'b0; tick(); tick(); tick();
        check("resume_data",  32'(out_data4), 32'h066);
        check("resume_valid", 32'(out_valid4), 1);
        tick();

        // random valid/ready, varying pressure
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (i < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            in_data   = 8'($urandom);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
        check("rand_drain4", 32'(occ4), 0);
        check("rand_drain1", 32'(occ1), 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
